// File: rtl/lifo_arbiter_pkg.sv
// Shared types for the LIFO arbiter: FSM states, decoded client operations
// and the pop-tag record that travels alongside each LIFO access.
package lifo_arb_pkg;

  // Tag id field is wide enough for any practical client count; the top narrows it.
  localparam int TAG_IDW = 8;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    CLR
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_SWAP
  } op_t;

  typedef struct packed {
    logic               vld;
    logic [TAG_IDW-1:0] id;
  } tag_t;

  function automatic op_t decode_op(input logic push, input logic pop);
    op_t op;
    op = OP_NONE;
    if (push && pop) op = OP_SWAP;
    else if (push)   op = OP_PUSH;
    else if (pop)    op = OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/lifo_arbiter_if.sv
// Client-facing bundle of the LIFO arbiter: request/ack handshake plus the
// tagged pop-data return path.
interface lifo_arbiter_if #(
  parameter int CLIENTS = 4,
  parameter int DWIDTH  = 8,
  parameter int IDW     = $clog2(CLIENTS)
);

  logic [CLIENTS-1:0]        cli_push_i;
  logic [CLIENTS-1:0]        cli_pop_i;
  logic [CLIENTS*DWIDTH-1:0] cli_data_i;
  logic [CLIENTS-1:0]        cli_ack_o;
  logic                      rd_valid_o;
  logic [IDW-1:0]            rd_id_o;
  logic [DWIDTH-1:0]         rd_data_o;

  modport master (
    output cli_push_i, cli_pop_i, cli_data_i,
    input  cli_ack_o, rd_valid_o, rd_id_o, rd_data_o
  );

  modport slave (
    input  cli_push_i, cli_pop_i, cli_data_i,
    output cli_ack_o, rd_valid_o, rd_id_o, rd_data_o
  );

endinterface

// File: rtl/lifo_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first eligible requester at or after the
// slot following the last winner; the pointer only moves on a grant.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk_i,
  input  logic           srst_i,
  input  logic [N-1:0]   i_elig,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_id,
  output logic           o_valid
);

  logic [IDW-1:0] r_ptr;
  logic [N-1:0]   w_gnt;
  logic [IDW-1:0] w_id;
  logic           w_valid;
  int             w_idx;

  always_comb begin
    w_gnt   = '0;
    w_id    = '0;
    w_valid = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_valid && i_elig[w_idx]) begin
        w_valid      = 1'b1;
        w_gnt[w_idx] = 1'b1;
        w_id         = IDW'(w_idx);
      end
    end
  end

  // Reset parks the pointer on the last client so client 0 wins first.
  always_ff @(posedge clk_i) begin
    if (srst_i)       r_ptr <= IDW'(N - 1);
    else if (w_valid) r_ptr <= w_id;
  end

  assign o_gnt   = w_gnt;
  assign o_id    = w_id;
  assign o_valid = w_valid;

endmodule

// File: rtl/lifo_arbiter.sv
// Shares one LIFO between several clients: round-robin issue of push/pop/swap,
// shadow occupancy count, tagged pop-data return and a drain-then-clear sequence.
module lifo_arbiter
  import lifo_arb_pkg::*;
#(
  parameter int CLIENTS = 4,
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  lifo_arbiter_if.slave     cli,
  input  logic              clear_i,
  output logic              busy_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              lifo_srst_o,
  output logic              lifo_wrreq_o,
  output logic              lifo_rdreq_o,
  output logic [DWIDTH-1:0] lifo_data_o,
  input  logic [DWIDTH-1:0] lifo_q_i
);

  localparam int              IDW      = $clog2(CLIENTS);
  localparam int              DEPTH    = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH:0] ONE_CNT  = (AWIDTH + 1)'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AWIDTH:0]     r_cnt;
  logic [AWIDTH:0]     w_cnt_nxt;
  logic                r_wrreq;
  logic                r_rdreq;
  logic [DWIDTH-1:0]   r_data;
  tag_t                r_tag1;
  tag_t                r_tag2;
  tag_t                w_tag_in;

  logic [CLIENTS-1:0]  w_elig;
  logic [CLIENTS-1:0]  w_gnt;
  logic [IDW-1:0]      w_gnt_id;
  logic                w_gnt_vld;
  op_t                 w_op;
  logic [DWIDTH-1:0]   w_push_data;
  logic                w_wr_nxt;
  logic                w_rd_nxt;
  logic                w_rd_vld;

  // A swap only needs something to pop, so it is never blocked by a full LIFO.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      case (decode_op(cli.cli_push_i[i], cli.cli_pop_i[i]))
        OP_PUSH:         w_elig[i] = (r_cnt < FULL_CNT);
        OP_POP, OP_SWAP: w_elig[i] = (r_cnt != '0);
        default:         w_elig[i] = 1'b0;
      endcase
    end
    if (srst_i || (r_state != RUN)) w_elig = '0;
  end

  rr_arbiter #(
    .N   (CLIENTS),
    .IDW (IDW)
  ) u_rr (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .i_elig  (w_elig),
    .o_gnt   (w_gnt),
    .o_id    (w_gnt_id),
    .o_valid (w_gnt_vld)
  );

  always_comb begin
    w_op        = OP_NONE;
    w_push_data = '0;
    if (w_gnt_vld) begin
      w_op        = decode_op(cli.cli_push_i[w_gnt_id], cli.cli_pop_i[w_gnt_id]);
      w_push_data = cli.cli_data_i[int'(w_gnt_id) * DWIDTH +: DWIDTH];
    end
  end

  assign w_wr_nxt     = (w_op == OP_PUSH) || (w_op == OP_SWAP);
  assign w_rd_nxt     = (w_op == OP_POP)  || (w_op == OP_SWAP);
  assign w_tag_in.vld = w_rd_nxt;
  assign w_tag_in.id  = TAG_IDW'(w_gnt_id);

  always_comb begin
    w_cnt_nxt = r_cnt;
    case (w_op)
      OP_PUSH: w_cnt_nxt = r_cnt + ONE_CNT;
      OP_POP:  w_cnt_nxt = r_cnt - ONE_CNT;
      default: w_cnt_nxt = r_cnt;
    endcase
    if (r_state == CLR) w_cnt_nxt = '0;
  end

  // DRAIN holds off the LIFO reset until every issued pop has returned its data.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (clear_i) w_state_nxt = DRAIN;
      DRAIN:   if (!r_tag1.vld && !r_tag2.vld) w_state_nxt = CLR;
      CLR:     w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_cnt   <= '0;
      r_wrreq <= 1'b0;
      r_rdreq <= 1'b0;
      r_data  <= '0;
      r_tag1  <= '0;
      r_tag2  <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_wrreq <= w_wr_nxt;
      r_rdreq <= w_rd_nxt;
      r_data  <= w_wr_nxt ? w_push_data : '0;
      if (r_state == CLR) begin
        r_tag1 <= '0;
        r_tag2 <= '0;
      end else begin
        r_tag1 <= w_tag_in;
        r_tag2 <= r_tag1;
      end
    end
  end

  // Everything except the LIFO reset reads as zero while srst_i is held.
  assign w_rd_vld       = r_tag2.vld && !srst_i;
  assign cli.cli_ack_o  = w_gnt;
  assign cli.rd_valid_o = w_rd_vld;
  assign cli.rd_id_o    = w_rd_vld ? IDW'(r_tag2.id) : '0;
  assign cli.rd_data_o  = w_rd_vld ? lifo_q_i : '0;

  assign busy_o       = !srst_i && (r_state != RUN);
  assign usedw_o      = srst_i ? '0 : r_cnt;
  assign lifo_srst_o  = srst_i || (r_state == CLR);
  assign lifo_wrreq_o = r_wrreq && !srst_i;
  assign lifo_rdreq_o = r_rdreq && !srst_i;
  assign lifo_data_o  = srst_i ? '0 : r_data;

endmodule
